// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   tx_state_t        - transmit FSM state encoding
//   UART_*_OFS        - register byte offsets from IO_BASE
//   STAT_*            - bit positions inside the STATUS word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [31:0] UART_DATA_OFS = 32'd0;
  localparam logic [31:0] UART_STAT_OFS = 32'd4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_PAR     = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: core data-memory port as seen by an MMIO peripheral.
//   addr      core data address
//   memWdata  store data
//   memWMask  byte write mask (nonzero = store)
//   memRstrb  load strobe
//   rdata     peripheral read data (combinational)
// master = core side, slave = peripheral side.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] memWdata;
  logic [3:0]  memWMask;
  logic        memRstrb;
  logic [31:0] rdata;

  modport master (output addr, memWdata, memWMask, memRstrb, input rdata);
  modport slave  (input addr, memWdata, memWMask, memRstrb, output rdata);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two.
//   clk, reset  clock, synchronous active-high reset (flushes)
//   push, din   write request / data (ignored when full unless popping)
//   pop, dout   read request / head-of-queue data (dout valid when !empty)
//   full, empty, count  occupancy flags and count (one bit wider than pointers)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // A pop frees the slot on the same edge, so push-while-full is legal then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the core data port.
//   clk, reset  core clock, synchronous active-high reset
//   bus         core data port (slave modport): stores to IO_BASE push a byte,
//               loads of IO_BASE+4 return STATUS {count[15:8], par, ovf, busy, full}
//   tx          serial line, idle high, LSB first, registered
//   busy        registered: frame in flight or FIFO non-empty
// Build option: define UART_TX_PARITY_EN for 8E1 framing (even parity bit,
// STATUS bit3 = 1); default is 8N1.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] IO_BASE      = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_mmio_if.slave    bus,
  output logic             tx,
  output logic             busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  logic          sel_data, sel_stat, push, pop, full, empty;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;

  tx_state_t     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;
  logic          baud_done;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  // Only byte lane 0 of a DATA store is meaningful.
  logic unused_bits;
  assign unused_bits = ^{bus.memWdata[31:8], bus.memWMask[3:1]};

  assign sel_data = (bus.addr == IO_BASE + UART_DATA_OFS);
  assign sel_stat = (bus.addr == IO_BASE + UART_STAT_OFS);
  assign push     = sel_data & bus.memWMask[0];

  assign baud_done = (baud_q == '0);
  // Pop when idle, or at the very end of STOP so the next start bit follows with no gap.
  assign pop = ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.memWdata[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow; a same-edge overflow wins over the read-clear.
  always_comb begin
    ovf_d = ovf_q;
    if (sel_stat & bus.memRstrb) ovf_d = 1'b0;
    if (push & full & ~pop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_comb begin
    status                       = '0;
    status[STAT_FULL]            = full;
    status[STAT_BUSY]            = busy_q;
    status[STAT_OVF]             = ovf_q;
    status[STAT_CNT_LSB +: 8]    = 8'(count);
`ifdef UART_TX_PARITY_EN
    status[STAT_PAR]             = 1'b1;
`endif
  end

  assign bus.rdata = sel_stat ? status : '0;

  // tx_q is loaded with the value of the bit being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != IDLE) | ~empty;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= dout;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^dout;
`endif
            baud_q  <= BAUD_LOAD;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            idx_q   <= '0;
            baud_q  <= BAUD_LOAD;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_LOAD;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_q  <= BAUD_LOAD;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= dout;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^dout;
`endif
              baud_q  <= BAUD_LOAD;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8): a serial monitor
// decodes frames on tx and checks them against a queue of expected bytes.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] STAT  = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
  localparam int          PX        = 1;
  localparam logic [31:0] IDLE_STAT = 32'h8;
`else
  localparam int          PX        = 0;
  localparam logic [31:0] IDLE_STAT = 32'h0;
`endif
  localparam int FRAME = (10 + PX) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard + serial monitor ----------------
  logic [7:0] exp_q[$];
  int         falls[$];
  int         frames  = 0;
  bit         mon_act = 0;

  task automatic mw(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      ab |= reset;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic       st, sp, pb;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        mon_act = 1;
        ab = 0;
        pb = 0;
        falls.push_back(cyc);
        mw(CPB / 2, ab);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          mw(CPB, ab);
          b[i] = tx;
        end
        if (PX == 1) begin
          mw(CPB, ab);
          pb = tx;
        end
        mw(CPB, ab);
        sp = tx;
        mw(CPB - CPB / 2 - 1, ab);
        if (!ab) begin
          chk("start_bit", 32'(st), 32'd0);
          chk("stop_bit", 32'(sp), 32'd1);
          if (PX == 1) chk("parity_bit", 32'(pb), 32'(^b));
          chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
          frames++;
        end
        mon_act = 0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- driver helpers ----------------
  int last_s;

  task automatic store(input logic [31:0] a, input logic [7:0] b, input logic [3:0] m, input bit acc);
    bus.addr     = a;
    bus.memWdata = {24'hA5A5A5, b};
    bus.memWMask = m;
    bus.memRstrb = 1'b0;
    if (acc) exp_q.push_back(b);
    @(posedge clk);
    #1;
    last_s       = cyc;
    bus.memWMask = 4'h0;
    bus.addr     = 32'h0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || mon_act) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  // One isolated frame: latency, length and busy tail.
  task automatic single_frame(input logic [7:0] b);
    int s, f0;
    f0 = frames;
    store(BASE, b, 4'h1, 1);
    s = last_s;
    @(negedge clk);
    chk("tx_before_pop", 32'(tx), 32'd1);
    wait_cyc(s + 1);
    chk("tx_fall", 32'(tx), 32'd0);
    wait_cyc(s + FRAME);
    chk("tx_last_stop", 32'(tx), 32'd1);
    chk("busy_last_stop", 32'(busy), 32'd1);
    wait_cyc(s + FRAME + 1);
    chk("busy_hold", 32'(busy), 32'd1);
    chk("tx_after_frame", 32'(tx), 32'd1);
    wait_cyc(s + FRAME + 2);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("single_frames", 32'(frames - f0), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int f0, s;
    bus.addr     = 32'h0;
    bus.memWdata = 32'h0;
    bus.memWMask = 4'h0;
    bus.memRstrb = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset / idle state.
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    bus.addr = STAT;
    #1 chk("idle_stat", bus.rdata, IDLE_STAT);
    bus.addr = BASE;
    #1 chk("data_reads_0", bus.rdata, 32'h0);
    bus.addr = 32'h1234_5678;
    #1 chk("other_reads_0", bus.rdata, 32'h0);

    // Stores that must not push: to STATUS, and to DATA without lane 0.
    store(STAT, 8'h77, 4'hF, 0);
    store(BASE, 8'h66, 4'b1110, 0);
    repeat (3) @(negedge clk);
    bus.addr = STAT;
    #1 chk("ignored_stores", bus.rdata, IDLE_STAT);
    chk("ignored_no_frame", 32'(frames), 32'd0);

    // Single frame 0x55.
    single_frame(8'h55);
`ifdef UART_TX_PARITY_EN
    single_frame(8'h07);
`endif

    // Three back-to-back frames.
    falls.delete();
    f0 = frames;
    store(BASE, 8'hA1, 4'h1, 1);
    store(BASE, 8'hB2, 4'h3, 1);
    store(BASE, 8'hC3, 4'hF, 1);
    bus.addr = STAT;
    @(negedge clk);
    chk("b2b_count", 32'(bus.rdata[15:8]), 32'd2);
    chk("b2b_stat", bus.rdata, 32'h0000_0202 | IDLE_STAT);
    bus.addr = 32'h0;
    drain(600);
    chk("b2b_frames", 32'(frames - f0), 32'd3);
    chk("b2b_falls", 32'(falls.size()), 32'd3);
    if (falls.size() == 3) begin
      chk("b2b_gap01", 32'(falls[1] - falls[0]), 32'(FRAME));
      chk("b2b_gap12", 32'(falls[2] - falls[1]), 32'(FRAME));
    end

    // Overflow: 10 stores, the first drains immediately so DEPTH+1 survive.
    f0 = frames;
    for (int i = 0; i < 10; i++) store(BASE, 8'(8'h10 + i), 4'h1, i <= DEPTH);
    bus.addr = STAT;
    @(negedge clk);
    chk("ovf_stat", bus.rdata, 32'h0000_0807 | IDLE_STAT);
    bus.memRstrb = 1'b1;
    #1 chk("ovf_rd_first", 32'(bus.rdata[2]), 32'd1);
    @(posedge clk);
    #1 bus.memRstrb = 1'b0;
    @(negedge clk);
    chk("ovf_rd_second", 32'(bus.rdata[2]), 32'd0);
    chk("ovf_still_full", 32'(bus.rdata[0]), 32'd1);
    bus.addr = 32'h0;
    drain(2000);
    chk("ovf_frames", 32'(frames - f0), 32'(DEPTH + 1));
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with bytes still queued.
    store(BASE, 8'hC3, 4'h1, 1);
    s = last_s;
    store(BASE, 8'h11, 4'h1, 1);
    store(BASE, 8'h22, 4'h1, 1);
    wait_cyc(s + 15);
    reset    = 1'b1;
    bus.addr = STAT;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stat", bus.rdata, IDLE_STAT);
    exp_q.delete();
    f0 = frames;
    #1 reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_no_frames", 32'(frames - f0), 32'd0);
    chk("rst_tx_idle", 32'(tx), 32'd1);
    chk("rst_stat_after", bus.rdata, IDLE_STAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
